// File: rtl/uparc_memory_access.sv
// uParc memory-access stage: drives load/store transactions on the data bus and registers write-back.
// Optional macro UPARC_LSU_ALIGN_CHECK_EN enables misalignment detection and request suppression.
module uparc_memory_access #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_exec_stall,
    input  logic              i_fetch_stall,
    input  logic              i_wait_stall,
    input  logic              i_nullify,
    output logic              o_mem_stall,
    output logic              o_addr_error,
    input  logic [4:0]        i_rd_no,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [1:0]        i_lsu_op,
    input  logic              i_lsu_lns,
    input  logic              i_lsu_ext,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic              o_bus_req,
    output logic              o_bus_rnw,
    output logic [3:0]        o_bus_ben,
    output logic [DATA_W-1:0] o_bus_wdata,
    input  logic              i_bus_ack,
    input  logic [DATA_W-1:0] i_bus_rdata,
    input  logic              i_bus_rdy,
    output logic [4:0]        o_rd_no,
    output logic [DATA_W-1:0] o_rd_val
);

    localparam logic [1:0] OP_IDLE  = 2'd0;
    localparam logic [1:0] OP_BYTE  = 2'd1;
    localparam logic [1:0] OP_HWORD = 2'd2;
    localparam logic [1:0] OP_WORD  = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic              access;
    logic              misaligned;
    logic              core_stall;
    logic              start;
    logic              req_clear;
    logic              capture;
    logic              is_load;
    logic [1:0]        addr_lo;
    logic [DATA_W-1:0] load_word;
    logic [4:0]        wb_no;
    logic [DATA_W-1:0] wb_val;

    function automatic logic [3:0] lane_ben(input logic [1:0] op, input logic [1:0] lo);
        case (op)
            OP_BYTE:  return 4'b0001 << lo;
            OP_HWORD: return lo[1] ? 4'b1100 : 4'b0011;
            OP_WORD:  return 4'b1111;
            default:  return 4'b0000;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] lane_wdata(input logic [1:0] op,
                                                     input logic [DATA_W-1:0] data);
        case (op)
            OP_BYTE:  return {4{data[7:0]}};
            OP_HWORD: return {2{data[15:0]}};
            default:  return data;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] word,
                                                       input logic [1:0] op,
                                                       input logic [1:0] lo,
                                                       input logic ext);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (op)
            OP_BYTE:  return {{(DATA_W-8){ext & b[7]}}, b};
            OP_HWORD: return {{(DATA_W-16){ext & h[15]}}, h};
            default:  return word;
        endcase
    endfunction

`ifdef UPARC_LSU_ALIGN_CHECK_EN
    always_comb begin
        misaligned = ((i_lsu_op == OP_HWORD) && i_alu_result[0]) ||
                     ((i_lsu_op == OP_WORD) && (i_alu_result[1:0] != 2'b00));
        addr_lo    = i_alu_result[1:0];
    end
`else
    // Without checking, low address bits are forced to the natural alignment of the size.
    always_comb begin
        misaligned = 1'b0;
        case (i_lsu_op)
            OP_HWORD: addr_lo = {i_alu_result[1], 1'b0};
            OP_WORD:  addr_lo = 2'b00;
            default:  addr_lo = i_alu_result[1:0];
        endcase
    end
`endif

    assign access       = (i_lsu_op != OP_IDLE) & ~i_nullify;
    assign o_addr_error = access & misaligned;
    assign core_stall   = i_exec_stall | o_mem_stall | i_fetch_stall | i_wait_stall;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (access && !misaligned) state_next = S_CMD;
            S_CMD:  if (i_bus_ack) state_next = (!o_bus_rnw || i_bus_rdy) ? S_DONE : S_DATA;
            S_DATA: if (i_bus_rdy) state_next = S_DONE;
            S_DONE: if (!core_stall) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Once a transaction leaves IDLE it runs to completion; nullify only matters at advance.
    always_comb begin
        o_mem_stall = 1'b0;
        start       = 1'b0;
        req_clear   = 1'b0;
        capture     = 1'b0;
        case (state)
            S_IDLE: begin
                start       = access & ~misaligned;
                o_mem_stall = access & ~misaligned;
            end
            S_CMD: begin
                o_mem_stall = 1'b1;
                req_clear   = i_bus_ack;
                capture     = i_bus_ack & i_bus_rdy & o_bus_rnw;
            end
            S_DATA: begin
                o_mem_stall = 1'b1;
                capture     = i_bus_rdy;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            o_bus_req   <= 1'b0;
            o_bus_rnw   <= 1'b1;
            o_bus_ben   <= 4'b0000;
            o_bus_addr  <= '0;
            o_bus_wdata <= '0;
        end else if (start) begin
            o_bus_req   <= 1'b1;
            o_bus_rnw   <= i_lsu_lns;
            o_bus_ben   <= lane_ben(i_lsu_op, addr_lo);
            o_bus_addr  <= {i_alu_result[ADDR_W-1:2], 2'b00};
            o_bus_wdata <= lane_wdata(i_lsu_op, i_mem_data);
        end else if (req_clear) begin
            o_bus_req   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            load_word <= i_bus_rdata;
        end
    end

    // Execute-stage inputs are frozen by the stall, so extraction reuses them at advance.
    always_comb begin
        is_load = access & i_lsu_lns & ~misaligned;
        wb_no   = (i_nullify || o_addr_error || ((i_lsu_op != OP_IDLE) && !i_lsu_lns))
                  ? 5'd0 : i_rd_no;
        wb_val  = is_load ? load_extract(load_word, i_lsu_op, addr_lo, i_lsu_ext) : i_alu_result;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            o_rd_no  <= 5'd0;
            o_rd_val <= '0;
        end else if (!core_stall) begin
            o_rd_no  <= wb_no;
            o_rd_val <= wb_val;
        end
    end

endmodule

// File: tb/tb_uparc_memory_access.sv
// Directed bench for uparc_memory_access: table of single ops plus stall, nullify and reset sequences.
module tb_uparc_memory_access;

    logic        clk = 1'b0;
    logic        nrst;
    logic        i_exec_stall, i_fetch_stall, i_wait_stall, i_nullify;
    logic        o_mem_stall, o_addr_error;
    logic [4:0]  i_rd_no;
    logic [31:0] i_alu_result;
    logic [1:0]  i_lsu_op;
    logic        i_lsu_lns, i_lsu_ext;
    logic [31:0] i_mem_data;
    logic [31:0] o_bus_addr;
    logic        o_bus_req, o_bus_rnw;
    logic [3:0]  o_bus_ben;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ack, i_bus_rdy;
    logic [31:0] i_bus_rdata;
    logic [4:0]  o_rd_no;
    logic [31:0] o_rd_val;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uparc_memory_access dut (
        .clk(clk), .nrst(nrst),
        .i_exec_stall(i_exec_stall), .i_fetch_stall(i_fetch_stall),
        .i_wait_stall(i_wait_stall), .i_nullify(i_nullify),
        .o_mem_stall(o_mem_stall), .o_addr_error(o_addr_error),
        .i_rd_no(i_rd_no), .i_alu_result(i_alu_result), .i_lsu_op(i_lsu_op),
        .i_lsu_lns(i_lsu_lns), .i_lsu_ext(i_lsu_ext), .i_mem_data(i_mem_data),
        .o_bus_addr(o_bus_addr), .o_bus_req(o_bus_req), .o_bus_rnw(o_bus_rnw),
        .o_bus_ben(o_bus_ben), .o_bus_wdata(o_bus_wdata), .i_bus_ack(i_bus_ack),
        .i_bus_rdata(i_bus_rdata), .i_bus_rdy(i_bus_rdy),
        .o_rd_no(o_rd_no), .o_rd_val(o_rd_val)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [1:0]  op;
        logic        lns, ext, nul;
        logic [31:0] mdata, rdata;
        int          ack_dly;
        logic        rdy_same;
        logic        err;
        logic [31:0] addr;
        logic [3:0]  ben;
        logic        rnw;
        logic [31:0] wdata;
        int          reqs, stalls;
        logic [4:0]  exp_rd;
        logic [31:0] exp_val;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] rd, input logic [31:0] alu, input logic [1:0] op,
                                input logic lns, input logic ext, input logic nul,
                                input logic [31:0] mdata, input logic [31:0] rdata,
                                input int ack_dly, input logic rdy_same, input logic err,
                                input logic [31:0] addr, input logic [3:0] ben, input logic rnw,
                                input logic [31:0] wdata, input int reqs, input int stalls,
                                input logic [4:0] exp_rd, input logic [31:0] exp_val);
        vec_t v;
        v.rd = rd; v.alu = alu; v.op = op; v.lns = lns; v.ext = ext; v.nul = nul;
        v.mdata = mdata; v.rdata = rdata; v.ack_dly = ack_dly; v.rdy_same = rdy_same;
        v.err = err; v.addr = addr; v.ben = ben; v.rnw = rnw; v.wdata = wdata;
        v.reqs = reqs; v.stalls = stalls; v.exp_rd = exp_rd; v.exp_val = exp_val;
        return v;
    endfunction

    task automatic drive_op(input logic [4:0] rd, input logic [31:0] alu, input logic [1:0] op,
                            input logic lns, input logic ext, input logic nul, input logic [31:0] md);
        i_rd_no = rd; i_alu_result = alu; i_lsu_op = op;
        i_lsu_lns = lns; i_lsu_ext = ext; i_nullify = nul; i_mem_data = md;
    endtask

    // Called just after a rising edge; returns just after the edge on which the op advances.
    task automatic run_vec(input int idx, input vec_t v);
        int stalls, reqs, n;
        bit rdy_next;
        stalls = 0; reqs = 0; n = 0; rdy_next = 0;
        drive_op(v.rd, v.alu, v.op, v.lns, v.ext, v.nul, v.mdata);
        @(negedge clk);
        check($sformatf("v%0d_addr_error", idx), {31'd0, o_addr_error}, {31'd0, v.err});
        while (n < 40) begin
            i_bus_ack = 1'b0;
            i_bus_rdy = 1'b0;
            if (rdy_next) begin
                i_bus_rdy = 1'b1; i_bus_rdata = v.rdata; rdy_next = 0;
            end
            if (o_mem_stall) stalls++;
            if (o_bus_req) begin
                reqs++;
                check($sformatf("v%0d_bus_addr", idx), o_bus_addr, v.addr);
                check($sformatf("v%0d_bus_ben", idx), {28'd0, o_bus_ben}, {28'd0, v.ben});
                check($sformatf("v%0d_bus_rnw", idx), {31'd0, o_bus_rnw}, {31'd0, v.rnw});
                check($sformatf("v%0d_bus_wdata", idx), o_bus_wdata, v.wdata);
                if (reqs == v.ack_dly) begin
                    i_bus_ack = 1'b1;
                    if (v.rdy_same) begin
                        i_bus_rdy = 1'b1; i_bus_rdata = v.rdata;
                    end else if (v.lns) begin
                        rdy_next = 1;
                    end
                end
            end else if (!o_mem_stall) begin
                break;
            end
            @(negedge clk);
            n++;
        end
        check($sformatf("v%0d_no_timeout", idx), {31'd0, n < 40}, 32'd1);
        i_bus_ack = 1'b0;
        i_bus_rdy = 1'b0;
        @(posedge clk); #1;
        check($sformatf("v%0d_req_cycles", idx), reqs, v.reqs);
        check($sformatf("v%0d_stall_cycles", idx), stalls, v.stalls);
        check($sformatf("v%0d_rd_no", idx), {27'd0, o_rd_no}, {27'd0, v.exp_rd});
        check($sformatf("v%0d_rd_val", idx), o_rd_val, v.exp_val);
    endtask

    initial begin
        vec_t known;
        //            rd     alu           op    lns ext nul mdata          rdata        ack rs  err addr          ben     rnw wdata          rq st rd     val
        vecs[0]  = mk(5'd5,  32'h0000_1004, 2'd3, 1, 0, 0, 32'h0,         32'hDEADBEEF, 1, 0, 0, 32'h0000_1004, 4'hF,   1, 32'h0,         1, 3, 5'd5,  32'hDEADBEEF);
        vecs[1]  = mk(5'd3,  32'h0000_2003, 2'd1, 1, 1, 0, 32'h0,         32'h80112233, 1, 0, 0, 32'h0000_2000, 4'b1000,1, 32'h0,         1, 3, 5'd3,  32'hFFFFFF80);
        vecs[2]  = mk(5'd3,  32'h0000_2003, 2'd1, 1, 0, 0, 32'h0,         32'h80112233, 1, 0, 0, 32'h0000_2000, 4'b1000,1, 32'h0,         1, 3, 5'd3,  32'h00000080);
        vecs[3]  = mk(5'd9,  32'h0000_3002, 2'd2, 0, 0, 0, 32'h0000ABCD,  32'h0,        4, 0, 0, 32'h0000_3000, 4'b1100,0, 32'hABCDABCD,  4, 5, 5'd0,  32'h00003002);
        vecs[4]  = mk(5'd4,  32'h0000_4002, 2'd2, 1, 1, 0, 32'h0,         32'h80017FFF, 1, 1, 0, 32'h0000_4000, 4'b1100,1, 32'h0,         1, 2, 5'd4,  32'hFFFF8001);
        vecs[5]  = mk(5'd4,  32'h0000_4000, 2'd2, 1, 0, 0, 32'h0,         32'h12348765, 2, 0, 0, 32'h0000_4000, 4'b0011,1, 32'h0,         2, 4, 5'd4,  32'h00008765);
        vecs[6]  = mk(5'd10, 32'h0000_5001, 2'd1, 1, 1, 0, 32'h0,         32'h00007F00, 1, 0, 0, 32'h0000_5000, 4'b0010,1, 32'h0,         1, 3, 5'd10, 32'h0000007F);
        vecs[7]  = mk(5'd6,  32'h0000_6001, 2'd1, 0, 0, 0, 32'h000000A5,  32'h0,        1, 0, 0, 32'h0000_6000, 4'b0010,0, 32'hA5A5A5A5,  1, 2, 5'd0,  32'h00006001);
        vecs[8]  = mk(5'd11, 32'h0000_7000, 2'd3, 0, 0, 0, 32'h12345678,  32'h0,        3, 0, 0, 32'h0000_7000, 4'hF,   0, 32'h12345678,  3, 4, 5'd0,  32'h00007000);
        vecs[9]  = mk(5'd7,  32'h0000_0055, 2'd0, 0, 0, 0, 32'h0,         32'h0,        1, 0, 0, 32'h0,         4'h0,   0, 32'h0,         0, 0, 5'd7,  32'h00000055);
        vecs[10] = mk(5'd8,  32'h0000_0100, 2'd3, 1, 0, 1, 32'h0,         32'h0,        1, 0, 0, 32'h0,         4'h0,   0, 32'h0,         0, 0, 5'd0,  32'h00000100);
`ifdef UPARC_LSU_ALIGN_CHECK_EN
        vecs[11] = mk(5'd5,  32'h0000_1002, 2'd3, 1, 0, 0, 32'h0,         32'hCAFEF00D, 1, 0, 1, 32'h0,         4'h0,   1, 32'h0,         0, 0, 5'd0,  32'h00001002);
        vecs[12] = mk(5'd12, 32'h0000_2001, 2'd2, 1, 0, 0, 32'h0,         32'h1234ABCD, 1, 0, 1, 32'h0,         4'h0,   1, 32'h0,         0, 0, 5'd0,  32'h00002001);
`else
        vecs[11] = mk(5'd5,  32'h0000_1002, 2'd3, 1, 0, 0, 32'h0,         32'hCAFEF00D, 1, 0, 0, 32'h0000_1000, 4'hF,   1, 32'h0,         1, 3, 5'd5,  32'hCAFEF00D);
        vecs[12] = mk(5'd12, 32'h0000_2001, 2'd2, 1, 0, 0, 32'h0,         32'h1234ABCD, 1, 0, 0, 32'h0000_2000, 4'b0011,1, 32'h0,         1, 3, 5'd12, 32'h0000ABCD);
`endif

        nrst = 1'b0;
        i_exec_stall = 0; i_fetch_stall = 0; i_wait_stall = 0;
        i_bus_ack = 0; i_bus_rdy = 0; i_bus_rdata = 32'h0;
        drive_op(5'd0, 32'h0, 2'd0, 0, 0, 0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bus_req", {31'd0, o_bus_req}, 32'd0);
        check("rst_bus_rnw", {31'd0, o_bus_rnw}, 32'd1);
        check("rst_bus_ben", {28'd0, o_bus_ben}, 32'd0);
        check("rst_bus_addr", o_bus_addr, 32'd0);
        check("rst_bus_wdata", o_bus_wdata, 32'd0);
        check("rst_rd_no", {27'd0, o_rd_no}, 32'd0);
        check("rst_rd_val", o_rd_val, 32'd0);
        check("rst_mem_stall", {31'd0, o_mem_stall}, 32'd0);
        nrst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // Exec stall holds the write-back registers until it drops.
        known = mk(5'd2, 32'h22, 2'd0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h0, 4'h0, 0, 32'h0, 0, 0, 5'd2, 32'h22);
        run_vec(13, known);
        i_exec_stall = 1'b1;
        drive_op(5'd7, 32'h55, 2'd0, 0, 0, 0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("xstall_rd_no_held", {27'd0, o_rd_no}, 32'd2);
            check("xstall_rd_val_held", o_rd_val, 32'h22);
        end
        i_exec_stall = 1'b0;
        @(posedge clk); #1;
        check("xstall_rd_no_release", {27'd0, o_rd_no}, 32'd7);
        check("xstall_rd_val_release", o_rd_val, 32'h55);

        // Nullify raised mid-transaction: the bus access still completes, the op is squashed.
        drive_op(5'd9, 32'h40, 2'd3, 1, 0, 0, 32'h0);
        @(negedge clk);
        check("nul_idle_stall", {31'd0, o_mem_stall}, 32'd1);
        @(negedge clk);
        check("nul_cmd_req", {31'd0, o_bus_req}, 32'd1);
        i_nullify = 1'b1;
        i_bus_ack = 1'b1; i_bus_rdy = 1'b1; i_bus_rdata = 32'h11112222;
        #1;
        check("nul_cmd_stall_kept", {31'd0, o_mem_stall}, 32'd1);
        @(negedge clk);
        i_bus_ack = 1'b0; i_bus_rdy = 1'b0;
        check("nul_done_stall", {31'd0, o_mem_stall}, 32'd0);
        check("nul_done_req", {31'd0, o_bus_req}, 32'd0);
        @(posedge clk); #1;
        check("nul_rd_no", {27'd0, o_rd_no}, 32'd0);
        check("nul_rd_val", o_rd_val, 32'h40);
        i_nullify = 1'b0;

        // Reset while a load waits in DATA; the late response must be ignored.
        drive_op(5'd5, 32'h80, 2'd3, 1, 0, 0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("mrst_cmd_req", {31'd0, o_bus_req}, 32'd1);
        i_bus_ack = 1'b1;
        @(negedge clk);
        i_bus_ack = 1'b0;
        check("mrst_data_stall", {31'd0, o_mem_stall}, 32'd1);
        nrst = 1'b0;
        #1;
        check("mrst_bus_req", {31'd0, o_bus_req}, 32'd0);
        check("mrst_bus_rnw", {31'd0, o_bus_rnw}, 32'd1);
        check("mrst_bus_ben", {28'd0, o_bus_ben}, 32'd0);
        check("mrst_bus_addr", o_bus_addr, 32'd0);
        check("mrst_bus_wdata", o_bus_wdata, 32'd0);
        check("mrst_rd_no", {27'd0, o_rd_no}, 32'd0);
        check("mrst_rd_val", o_rd_val, 32'd0);
        drive_op(5'd0, 32'h0, 2'd0, 0, 0, 0, 32'h0);
        @(negedge clk);
        nrst = 1'b1;
        i_bus_rdy = 1'b1; i_bus_rdata = 32'h99999999;
        @(negedge clk);
        i_bus_rdy = 1'b0;
        check("mrst_after_stall", {31'd0, o_mem_stall}, 32'd0);
        check("mrst_after_req", {31'd0, o_bus_req}, 32'd0);
        @(posedge clk); #1;
        check("mrst_after_rd_no", {27'd0, o_rd_no}, 32'd0);
        check("mrst_after_rd_val", o_rd_val, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
